// File: rtl/mand_pkg.sv
// Shared constants and FSM encoding for the Mandelbrot pixel scheduler.
// Coordinates are Q7.20 signed; iteration counts are 32-bit signed.
package mand_pkg;

  localparam int Q_W    = 27;
  localparam int Q_FRAC = 20;
  localparam int ITER_W = 32;

  localparam logic signed [ITER_W-1:0] ITER_CONV = -32'sd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

endpackage

// File: rtl/mand_coord_stepper.sv
// Pixel counters and c accumulators, stepped in row-major order.
// c is updated by add/subtract only, wrapping at 27 bits.
module mand_coord_stepper
  import mand_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  advance,
  input  logic signed [Q_W-1:0] x0,
  input  logic signed [Q_W-1:0] y0,
  input  logic signed [Q_W-1:0] step,
  output logic [15:0]           x,
  output logic [15:0]           y,
  output logic signed [Q_W-1:0] c_re,
  output logic signed [Q_W-1:0] c_im,
  output logic                  last_pixel
);

  logic [15:0]           x_q, x_d;
  logic [15:0]           y_q, y_d;
  logic signed [Q_W-1:0] re_q, re_d;
  logic signed [Q_W-1:0] im_q, im_d;
  logic                  last_x;
  logic                  last_y;

  assign last_x     = (x_q == 16'(WIDTH - 1));
  assign last_y     = (y_q == 16'(HEIGHT - 1));
  assign last_pixel = last_x && last_y;

  // Next coordinate: reload on init, otherwise step along the row or wrap.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    re_d = re_q;
    im_d = im_q;
    if (init) begin
      x_d  = '0;
      y_d  = '0;
      re_d = x0;
      im_d = y0;
    end else if (advance) begin
      if (!last_x) begin
        x_d  = x_q + 16'd1;
        re_d = re_q + step;
      end else if (!last_y) begin
        x_d  = '0;
        y_d  = y_q + 16'd1;
        re_d = x0;
        im_d = im_q - step;
      end
    end
  end

  // Coordinate state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign c_re = re_q;
  assign c_im = im_q;

endmodule

// File: rtl/mand_scheduler.sv
// Walks a frame pixel by pixel, restarting the solver for each c
// and handing its iteration count out on a valid/ready port.
module mand_scheduler
  import mand_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [Q_W-1:0]    x0,
  input  logic signed [Q_W-1:0]    y0,
  input  logic signed [Q_W-1:0]    step,
  output logic                     solver_reset,
  output logic signed [Q_W-1:0]    solver_c_re,
  output logic signed [Q_W-1:0]    solver_c_im,
  input  logic                     solver_ready,
  input  logic signed [ITER_W-1:0] solver_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_x,
  output logic [15:0]              res_y,
  output logic signed [ITER_W-1:0] res_iter,
  output logic                     busy,
  output logic                     done
);

  state_t                  state_q;
  logic signed [Q_W-1:0]   x0_q, y0_q, step_q;
  logic                    first_q;
  logic                    sreset_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic [15:0]             rx_q, ry_q;
  logic signed [ITER_W-1:0] iter_q;

  logic                    init;
  logic                    advance;
  logic                    last_pixel;
  logic [15:0]             cur_x, cur_y;
  logic signed [Q_W-1:0]   op_x0, op_y0, op_step;

  assign init    = (state_q == S_IDLE) && start;
  assign advance = (state_q == S_EMIT) && res_ready && !last_pixel;

  // At init the fresh operands are used; afterwards the latched copies.
  assign op_x0   = init ? x0   : x0_q;
  assign op_y0   = init ? y0   : y0_q;
  assign op_step = init ? step : step_q;

  mand_coord_stepper #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_step (
    .clock      (clock),
    .reset      (reset),
    .init       (init),
    .advance    (advance),
    .x0         (op_x0),
    .y0         (op_y0),
    .step       (op_step),
    .x          (cur_x),
    .y          (cur_y),
    .c_re       (solver_c_re),
    .c_im       (solver_c_im),
    .last_pixel (last_pixel)
  );

  // Pixel FSM with all status and result outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      step_q   <= '0;
      first_q  <= 1'b0;
      sreset_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      iter_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x0_q     <= x0;
            y0_q     <= y0;
            step_q   <= step;
            sreset_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          sreset_q <= 1'b0;
          first_q  <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          first_q <= 1'b0;
          if (!first_q && solver_ready) begin
            iter_q  <= solver_out;
            rx_q    <= cur_x;
            ry_q    <= cur_y;
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            if (last_pixel) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              sreset_q <= 1'b1;
              state_q  <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign solver_reset = sreset_q;
  assign res_valid    = valid_q;
  assign res_x        = rx_q;
  assign res_y        = ry_q;
  assign res_iter     = iter_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mand_scheduler.sv
// Directed bench for mand_scheduler on a 2x2 frame with a stub solver.
// Expected coordinates and counts are hand-computed Q7.20 constants.
module tb_mand_scheduler;

  localparam int ONE = 1 << 20;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [26:0] x0, y0, step;
  logic               solver_reset;
  logic signed [26:0] solver_c_re, solver_c_im;
  logic               solver_ready;
  logic signed [31:0] solver_out;
  logic               res_valid;
  logic               res_ready;
  logic [15:0]        res_x, res_y;
  logic signed [31:0] res_iter;
  logic               busy, done;

  int lat  = 3;
  int scnt = 0;
  int n_chk = 0;
  int n_err = 0;

  int cre_q[$], cim_q[$], rx_q[$], ry_q[$], rit_q[$], hs_q[$];
  int done_cnt;

  always #5 clock = ~clock;

  mand_scheduler #(
    .WIDTH  (2),
    .HEIGHT (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .x0           (x0),
    .y0           (y0),
    .step         (step),
    .solver_reset (solver_reset),
    .solver_c_re  (solver_c_re),
    .solver_c_im  (solver_c_im),
    .solver_ready (solver_ready),
    .solver_out   (solver_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_iter     (res_iter),
    .busy         (busy),
    .done         (done)
  );

  // Stub solver: ready in the lat-th cycle after its restart pulse.
  always @(posedge clock) begin
    if (solver_reset) scnt <= 1;
    else if (scnt != 0 && scnt < lat) scnt <= scnt + 1;
  end
  assign solver_ready = (scnt == lat);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record solver restarts and result handshakes until done or timeout.
  // At cycle inj a stray start with a different x0 is injected.
  task automatic collect(input int max_cyc, input int inj);
    bit fin = 1'b0;
    cre_q.delete(); cim_q.delete();
    rx_q.delete(); ry_q.delete();
    rit_q.delete(); hs_q.delete();
    done_cnt = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i == inj) begin
        start = 1'b1;
        x0    = 27'sd0;
      end else begin
        start = 1'b0;
      end
      if (solver_reset) begin
        cre_q.push_back(int'(solver_c_re));
        cim_q.push_back(int'(solver_c_im));
      end
      if (res_valid && res_ready) begin
        rx_q.push_back(int'(res_x));
        ry_q.push_back(int'(res_y));
        rit_q.push_back(int'(res_iter));
        hs_q.push_back(i);
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    chk("frame_timeout", int'(fin), 1);
  endtask

  int exp_re[4];
  int exp_im[4];
  int exp_x[4];
  int exp_y[4];
  int sx, sy, si;
  int bad_v, bad_f, bad_r;
  logic [31:0] u;

  initial begin
    exp_re = '{-2 * ONE, -3 * ONE / 2, -2 * ONE, -3 * ONE / 2};
    exp_im = '{ONE, ONE, ONE / 2, ONE / 2};
    exp_x  = '{0, 1, 0, 1};
    exp_y  = '{0, 0, 1, 1};

    x0 = 27'(-2 * ONE);
    y0 = 27'(ONE);
    step = 27'(ONE / 2);
    res_ready = 1'b1;
    solver_out = 32'sd7;

    tick();
    tick();
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sreset", int'(solver_reset), 0);
    chk("rst_x", int'(res_x), 0);
    chk("rst_y", int'(res_y), 0);
    chk("rst_iter", int'(res_iter), 0);
    chk("rst_cre", int'(solver_c_re), 0);
    chk("rst_cim", int'(solver_c_im), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    pulse_start();
    chk("load_busy", int'(busy), 1);
    collect(200, -1);
    chk("n_c", cre_q.size(), 4);
    chk("n_res", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c_re%0d", k), cre_q[k], exp_re[k]);
      chk($sformatf("c_im%0d", k), cim_q[k], exp_im[k]);
      chk($sformatf("res_x%0d", k), rx_q[k], exp_x[k]);
      chk($sformatf("res_y%0d", k), ry_q[k], exp_y[k]);
      chk($sformatf("iter%0d", k), rit_q[k], 7);
    end
    chk("period01", hs_q[1] - hs_q[0], 5);
    chk("period23", hs_q[3] - hs_q[2], 5);
    chk("done_cnt", done_cnt, 1);
    chk("done_busy", int'(busy), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_done", int'(solver_reset), 1);
    chk("start_on_done_busy", int'(busy), 1);
    chk("done_single", int'(done), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("run_rst_busy", int'(busy), 0);
    chk("run_rst_valid", int'(res_valid), 0);
    chk("run_rst_sreset", int'(solver_reset), 0);
    reset = 1'b0;
    tick();

    pulse_start();
    collect(200, 1);
    x0 = 27'(-2 * ONE);
    chk("restart_n", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rs_re%0d", k), cre_q[k], exp_re[k]);
      chk($sformatf("rs_im%0d", k), cim_q[k], exp_im[k]);
      chk($sformatf("rs_x%0d", k), rx_q[k], exp_x[k]);
      chk($sformatf("rs_y%0d", k), ry_q[k], exp_y[k]);
    end
    tick();

    solver_out = -32'sd1;
    res_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    chk("bp_valid", int'(res_valid), 1);
    u = res_iter;
    chk("iter_neg1", int'(u == 32'hFFFF_FFFF), 1);
    chk("bp_x0", int'(res_x), 0);
    sx = int'(res_x);
    sy = int'(res_y);
    si = int'(res_iter);
    bad_v = 0;
    bad_f = 0;
    bad_r = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!res_valid) bad_v++;
      if (int'(res_x) != sx || int'(res_y) != sy || int'(res_iter) != si)
        bad_f++;
      if (solver_reset) bad_r++;
    end
    chk("bp_hold_valid", bad_v, 0);
    chk("bp_hold_fields", bad_f, 0);
    chk("bp_no_sreset", bad_r, 0);
    res_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_load", int'(solver_reset), 1);
    collect(200, -1);
    chk("bp_rest_n", rx_q.size(), 3);
    chk("bp_rest_x", rx_q[0], 1);
    chk("bp_rest_y", ry_q[0], 0);
    tick();

    solver_out = 32'sd7;
    x0 = 27'(127 * ONE / 2);
    y0 = 27'sd0;
    step = 27'(ONE);
    pulse_start();
    collect(200, -1);
    chk("wrap_re0", cre_q[0], 127 * ONE / 2);
    chk("wrap_re1", cre_q[1], -127 * ONE / 2);
    chk("wrap_im2", cim_q[2], -ONE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
